// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: boot-loads a program into instruction memory,
// then streams one instruction per cycle to decode with stall, redirect and halt.
module fetch_ctrl #(
    parameter int                         ADDRESS_WIDTH = 32,
    parameter int                         DATA_WIDTH    = 32,
    parameter int                         MEM_SIZE      = 256,
    parameter logic [ADDRESS_WIDTH-1:0]   RESET_PC      = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     load_en,
    input  logic                     load_valid,
    input  logic [DATA_WIDTH-1:0]    load_data,
    output logic                     load_ready,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic                     mem_we,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    input  logic [DATA_WIDTH-1:0]    mem_rdata,
    output logic                     inst_valid,
    output logic [DATA_WIDTH-1:0]    inst,
    output logic [ADDRESS_WIDTH-1:0] inst_pc,
    input  logic                     inst_ready,
    input  logic                     redirect_valid,
    input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
    input  logic                     halt,
    output logic [1:0]               state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_HALT = 2'd3
    } state_t;

    // load_ptr must be able to hold MEM_SIZE itself (the "full" value)
    localparam int               PTR_W    = $clog2(MEM_SIZE + 1);
    localparam logic [PTR_W-1:0] PTR_FULL = PTR_W'(MEM_SIZE);

    state_t                   state_q, state_d;
    logic [PTR_W-1:0]         load_ptr_q, load_ptr_d;
    logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
    logic [ADDRESS_WIDTH-1:0] inst_pc_q, inst_pc_d;
    logic [DATA_WIDTH-1:0]    inst_q, inst_d;
    logic                     inst_valid_q, inst_valid_d;
    logic                     load_xfer;
    logic                     load_last;
    logic                     fetch_go;
    logic                     unused_redirect_lo;

    assign unused_redirect_lo = ^redirect_pc[1:0];

    // Gating with rst_n keeps a reset edge from also committing a write.
    always_comb begin
        load_ready = rst_n && (state_q == S_LOAD) && (load_ptr_q < PTR_FULL);
        load_xfer  = load_ready && load_valid;
        load_last  = load_xfer && (load_ptr_q == PTR_FULL - PTR_W'(1));
        mem_we     = load_xfer;
        mem_wdata  = load_data;
        mem_addr   = (state_q == S_LOAD) ? (ADDRESS_WIDTH'(load_ptr_q) << 2) : pc_q;
        fetch_go   = !inst_valid_q || inst_ready;
    end

    always_comb begin
        state_d      = state_q;
        load_ptr_d   = load_ptr_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_valid_d = inst_valid_q;

        if (load_xfer) begin
            load_ptr_d = load_ptr_q + PTR_W'(1);
        end

        case (state_q)
            S_IDLE, S_HALT: begin
                if (load_en) begin
                    state_d    = S_LOAD;
                    load_ptr_d = '0;
                end else if (start) begin
                    state_d      = S_RUN;
                    pc_d         = RESET_PC;
                    inst_valid_d = 1'b0;
                end
            end
            S_LOAD: begin
                // Leave on the edge that writes the last word, so ready drops right after it.
                if (!load_en || load_last || (load_ptr_q == PTR_FULL)) begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (halt) begin
                    state_d      = S_HALT;
                    inst_valid_d = 1'b0;
                end else if (redirect_valid) begin
                    pc_d         = {redirect_pc[ADDRESS_WIDTH-1:2], 2'b00};
                    inst_valid_d = 1'b0;
                end else if (fetch_go) begin
                    inst_d       = mem_rdata;
                    inst_pc_d    = pc_q;
                    inst_valid_d = 1'b1;
                    pc_d         = pc_q + ADDRESS_WIDTH'(4);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            load_ptr_q   <= '0;
            pc_q         <= RESET_PC;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            inst_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            load_ptr_q   <= load_ptr_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_valid_q <= inst_valid_d;
        end
    end

    assign inst_valid = inst_valid_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign state_o    = state_q;

endmodule
